// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: drives a single-outstanding imem port, steers the next PC
// from the BPU prediction and holds the IF/ID bundle (PC, word, prediction, trap bits).
module ifu_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = 32'h8000_0000,
  parameter int                TRAP_W   = 8,
  parameter logic [INST_W-1:0] INST_NOP = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] bpu_pc_o,
  input  logic              bpu_taken_i,
  input  logic [ADDR_W-1:0] bpu_target_i,
  output logic              imem_req_valid_o,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_data_i,
  input  logic              imem_resp_err_i,
  output logic              fetch_valid_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INST_W-1:0] inst_data_o,
  output logic              bpu_taken_o,
  output logic [TRAP_W-1:0] trap_bus_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, DROP} state_t;

  localparam logic [TRAP_W-1:0] TRAP_MISALIGN = TRAP_W'(1);
  localparam logic [TRAP_W-1:0] TRAP_FAULT    = TRAP_W'(2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              taken_q, taken_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] data_q, data_d;
  logic              btk_q, btk_d;
  logic [TRAP_W-1:0] trap_q, trap_d;
  logic              pc_aligned;
  logic              req_fire;

  // A trapped instruction never follows its prediction; it falls through sequentially.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc,
                                                input logic              taken,
                                                input logic [TRAP_W-1:0] trap,
                                                input logic [ADDR_W-1:0] tgt);
    return (taken && (trap == '0)) ? tgt : pc + ADDR_W'(4);
  endfunction

  assign pc_aligned       = (pc_q[1:0] == 2'b00);
  assign imem_req_valid_o = (state_q == REQ) && pc_aligned;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign bpu_pc_o         = pc_q;
  assign fetch_valid_o    = vld_q;
  assign inst_addr_o      = addr_q;
  assign inst_data_o      = data_q;
  assign bpu_taken_o      = btk_q;
  assign trap_bus_o       = trap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    taken_d = taken_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    btk_d   = btk_q;
    trap_d  = trap_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!pc_aligned) begin
          vld_d   = 1'b1;
          addr_d  = pc_q;
          data_d  = INST_NOP;
          btk_d   = 1'b0;
          trap_d  = TRAP_MISALIGN;
          state_d = VALID;
        end else if (imem_req_ready_i) begin
          taken_d = bpu_taken_i;
          tgt_d   = bpu_target_i;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid_i) begin
          vld_d   = 1'b1;
          addr_d  = pc_q;
          data_d  = imem_resp_err_i ? INST_NOP : imem_resp_data_i;
          btk_d   = imem_resp_err_i ? 1'b0 : taken_q;
          trap_d  = imem_resp_err_i ? TRAP_FAULT : '0;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!stall_i) begin
          pc_d    = next_pc(pc_q, btk_q, trap_q, tgt_q);
          vld_d   = 1'b0;
          data_d  = INST_NOP;
          btk_d   = 1'b0;
          trap_d  = '0;
          state_d = REQ;
        end
      end
      DROP: if (imem_resp_valid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything; an accepted request still owes us a response.
    if (flush_i) begin
      pc_d   = redirect_pc_i;
      vld_d  = 1'b0;
      data_d = INST_NOP;
      btk_d  = 1'b0;
      trap_d = '0;
      case (state_q)
        REQ:     state_d = req_fire ? DROP : REQ;
        WAIT,
        DROP:    state_d = imem_resp_valid_i ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= PC_RESET;
      tgt_q   <= '0;
      taken_q <= 1'b0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= INST_NOP;
      btk_q   <= 1'b0;
      trap_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      taken_q <= taken_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      btk_q   <= btk_d;
      trap_q  <= trap_d;
    end
  end

endmodule
